// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the cache-side request/ack lines and the external memory port of
// mem_arbiter.
//   slave  : arbiter view. It takes the cache requests and the memory response, and drives the
//            acks, the returned lines and the memory command.
//   master : environment view. Cache requesters and the memory model drive the opposite
//            direction.
// Parameters: ADDR_W (address width), LINE_W (cache-line / memory data width).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  // Icache refill path
  logic              ic_read_req;
  logic [ADDR_W-1:0] ic_read_addr;
  logic              ic_read_ack;
  logic [LINE_W-1:0] ic_read_data;
  // Dcache refill path
  logic              dc_read_req;
  logic [ADDR_W-1:0] dc_read_addr;
  logic              dc_read_ack;
  logic [LINE_W-1:0] dc_read_data;
  // Dcache write-back path
  logic              dc_write_req;
  logic [ADDR_W-1:0] dc_write_addr;
  logic [LINE_W-1:0] dc_write_data;
  logic              dc_write_ack;
  // External memory port
  logic              mem_enable;
  logic              mem_rw;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data_in;
  logic [LINE_W-1:0] mem_data_out;

  modport slave (
    input  ic_read_req, ic_read_addr,
    output ic_read_ack, ic_read_data,
    input  dc_read_req, dc_read_addr,
    output dc_read_ack, dc_read_data,
    input  dc_write_req, dc_write_addr, dc_write_data,
    output dc_write_ack,
    output mem_enable, mem_rw, mem_addr, mem_data_out,
    input  mem_ack, mem_data_in
  );

  modport master (
    output ic_read_req, ic_read_addr,
    input  ic_read_ack, ic_read_data,
    output dc_read_req, dc_read_addr,
    input  dc_read_ack, dc_read_data,
    output dc_write_req, dc_write_addr, dc_write_data,
    input  dc_write_ack,
    input  mem_enable, mem_rw, mem_addr, mem_data_out,
    output mem_ack, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the Icache refill, the Dcache refill
// and the Dcache write-back paths. At most one memory transaction is outstanding at a time.
// Ports:
//   clk   - single clock; all state changes on posedge
//   reset - synchronous, active-low
//   bus   - mem_arbiter_if.slave: three request/ack paths plus the memory command/response
// Every output comes straight from a register.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate between the Icache class and the
// Dcache class when both request. Without it, the priority is fixed:
// dc_write > dc_read > ic_read.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StBusyIc, StBusyDr, StBusyDw, StResp} state_e;

  state_e            r_state, w_state_next;
  logic              r_mem_enable, w_mem_enable_next;
  logic              r_mem_rw, w_mem_rw_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [LINE_W-1:0] r_mem_data_out, w_mem_data_out_next;
  logic              r_ic_ack, w_ic_ack_next;
  logic              r_dr_ack, w_dr_ack_next;
  logic              r_dw_ack, w_dw_ack_next;
  logic [LINE_W-1:0] r_ic_data, w_ic_data_next;
  logic [LINE_W-1:0] r_dc_data, w_dc_data_next;

  logic w_grant_ic, w_grant_dr, w_grant_dw;

`ifdef ARB_ROUND_ROBIN_EN
  // High when the Icache class won the most recent grant; reset value hands D the first turn.
  logic r_last_i, w_last_i_next;

  always_comb begin
    w_grant_ic = bus.ic_read_req &
                 (!(bus.dc_write_req | bus.dc_read_req) | !r_last_i);
  end
`else
  always_comb begin
    w_grant_ic = bus.ic_read_req & !(bus.dc_write_req | bus.dc_read_req);
  end
`endif

  // Inside the D class a write-back always beats a refill.
  always_comb begin
    w_grant_dw = !w_grant_ic & bus.dc_write_req;
    w_grant_dr = !w_grant_ic & !bus.dc_write_req & bus.dc_read_req;
  end

  always_comb begin
    w_state_next        = r_state;
    w_mem_enable_next   = r_mem_enable;
    w_mem_rw_next       = r_mem_rw;
    w_mem_addr_next     = r_mem_addr;
    w_mem_data_out_next = r_mem_data_out;
    w_ic_ack_next       = 1'b0;
    w_dr_ack_next       = 1'b0;
    w_dw_ack_next       = 1'b0;
    w_ic_data_next      = r_ic_data;
    w_dc_data_next      = r_dc_data;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_i_next       = r_last_i;
`endif

    unique case (r_state)
      StIdle: begin
        w_mem_enable_next = 1'b0;
        if (w_grant_dw) begin
          w_state_next        = StBusyDw;
          w_mem_enable_next   = 1'b1;
          w_mem_rw_next       = 1'b1;
          w_mem_addr_next     = bus.dc_write_addr;
          w_mem_data_out_next = bus.dc_write_data;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_i_next       = 1'b0;
`endif
        end else if (w_grant_dr) begin
          w_state_next      = StBusyDr;
          w_mem_enable_next = 1'b1;
          w_mem_rw_next     = 1'b0;
          w_mem_addr_next   = bus.dc_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_i_next     = 1'b0;
`endif
        end else if (w_grant_ic) begin
          w_state_next      = StBusyIc;
          w_mem_enable_next = 1'b1;
          w_mem_rw_next     = 1'b0;
          w_mem_addr_next   = bus.ic_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_i_next     = 1'b1;
`endif
        end
      end
      StBusyIc, StBusyDr, StBusyDw: begin
        if (bus.mem_ack) begin
          w_state_next      = StResp;
          w_mem_enable_next = 1'b0;
          w_ic_ack_next     = (r_state == StBusyIc);
          w_dr_ack_next     = (r_state == StBusyDr);
          w_dw_ack_next     = (r_state == StBusyDw);
          if (r_state == StBusyIc) w_ic_data_next = bus.mem_data_in;
          if (r_state == StBusyDr) w_dc_data_next = bus.mem_data_in;
        end
      end
      // Requests are not looked at here, so a requester still dropping its line is not
      // granted twice.
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next      = StIdle;
        w_mem_enable_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_mem_enable   <= 1'b0;
      r_mem_rw       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data_out <= '0;
      r_ic_ack       <= 1'b0;
      r_dr_ack       <= 1'b0;
      r_dw_ack       <= 1'b0;
      r_ic_data      <= '0;
      r_dc_data      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_i       <= 1'b1;
`endif
    end else begin
      r_state        <= w_state_next;
      r_mem_enable   <= w_mem_enable_next;
      r_mem_rw       <= w_mem_rw_next;
      r_mem_addr     <= w_mem_addr_next;
      r_mem_data_out <= w_mem_data_out_next;
      r_ic_ack       <= w_ic_ack_next;
      r_dr_ack       <= w_dr_ack_next;
      r_dw_ack       <= w_dw_ack_next;
      r_ic_data      <= w_ic_data_next;
      r_dc_data      <= w_dc_data_next;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_i       <= w_last_i_next;
`endif
    end
  end

  assign bus.mem_enable   = r_mem_enable;
  assign bus.mem_rw       = r_mem_rw;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_data_out = r_mem_data_out;
  assign bus.ic_read_ack  = r_ic_ack;
  assign bus.ic_read_data = r_ic_data;
  assign bus.dc_read_ack  = r_dr_ack;
  assign bus.dc_read_data = r_dc_data;
  assign bus.dc_write_ack = r_dw_ack;

endmodule
